// File: rtl/pump_ramp_ctrl.sv
// Pump motor sequencer: soft-start/soft-stop speed ramp, run timeout, restart lockout and estop fault handling.
// state | meaning: IDLE motor off | RAMP_UP accelerate | RUN track target | RAMP_DOWN decelerate | LOCKOUT off-time | FAULT estop latch
module pump_ramp_ctrl #(
    parameter int unsigned RAMP_DIV       = 50000,
    parameter int unsigned MIN_OFF_CYCLES = 100000000,
    parameter logic [31:0] MAX_RUN_CYCLES = 32'd3000000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_req,
    input  logic [7:0] target_speed,
    input  logic       estop,
    output logic       enable,
    output logic [7:0] speed,
    output logic       busy,
    output logic       fault,
    output logic       timeout,
    output logic [2:0] state
);

    localparam int unsigned PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'((RAMP_DIV > 0) ? RAMP_DIV - 1 : 0);
    localparam logic [31:0] OFF_LOAD = (MIN_OFF_CYCLES > 0) ? 32'(MIN_OFF_CYCLES - 1) : 32'd0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RUN       = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_LOCKOUT   = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [31:0]         off_cnt_q, off_cnt_d;
    logic [31:0]         run_cnt_q, run_cnt_d;
    logic [7:0]          speed_d, speed_ramp, goal;
    logic                timeout_d, enable_d, busy_d, fault_d;
    logic                tick, run_expired, ramping_q, ramping_d, ramp_entry;

    function automatic logic is_ramp(input state_t s);
        return (s == ST_RAMP_UP) || (s == ST_RUN) || (s == ST_RAMP_DOWN);
    endfunction

    always_comb begin
        ramping_q   = is_ramp(state_q);
        tick        = ramping_q && (presc_q == PRESC_LAST);
        run_expired = (run_cnt_q >= MAX_RUN_CYCLES);
        goal        = (state_q == ST_RAMP_DOWN) ? 8'd0 : target_speed;

        // one LSB per tick toward the goal; equality means no step, so no overshoot or wrap
        speed_ramp = speed;
        if (tick) begin
            if (speed < goal) begin
                speed_ramp = speed + 8'd1;
            end else if (speed > goal) begin
                speed_ramp = speed - 8'd1;
            end
        end
    end

    // next-state logic; branch order encodes estop > timeout > run_req drop > ramp done
    always_comb begin
        state_d   = state_q;
        timeout_d = timeout;
        case (state_q)
            ST_IDLE: begin
                if (estop) begin
                    state_d = ST_FAULT;
                end else if (run_req) begin
                    state_d   = ST_RAMP_UP;
                    timeout_d = 1'b0;
                end
            end
            ST_RAMP_UP: begin
                if (estop) begin
                    state_d = ST_FAULT;
                end else if (run_expired) begin
                    state_d   = ST_RAMP_DOWN;
                    timeout_d = 1'b1;
                end else if (!run_req) begin
                    state_d = ST_RAMP_DOWN;
                end else if (speed_ramp == target_speed) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (estop) begin
                    state_d = ST_FAULT;
                end else if (run_expired) begin
                    state_d   = ST_RAMP_DOWN;
                    timeout_d = 1'b1;
                end else if (!run_req) begin
                    state_d = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (estop) begin
                    state_d = ST_FAULT;
                end else if (speed_ramp == 8'd0) begin
                    state_d = ST_LOCKOUT;
                end
            end
            ST_LOCKOUT: begin
                if (estop) begin
                    state_d = ST_FAULT;
                end else if (off_cnt_q == 32'd0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (!estop && !run_req) begin
                    state_d = ST_LOCKOUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ramping_d  = is_ramp(state_d);
        ramp_entry = (state_d != state_q) &&
                     ((state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN));

        // prescaler phase carries over from RAMP_UP into RUN
        presc_d = '0;
        if (ramping_d && !ramp_entry && !tick) begin
            presc_d = presc_q + 1'b1;
        end

        speed_d  = ramping_d ? speed_ramp : 8'd0;
        enable_d = ramping_d;
        busy_d   = (state_d != ST_IDLE);
        fault_d  = (state_d == ST_FAULT);

        off_cnt_d = OFF_LOAD;
        if (state_q == ST_LOCKOUT) begin
            off_cnt_d = (off_cnt_q == 32'd0) ? 32'd0 : off_cnt_q - 32'd1;
        end

        run_cnt_d = run_cnt_q;
        if (state_q == ST_IDLE) begin
            run_cnt_d = 32'd0;
        end else if (enable && (run_cnt_q != 32'hFFFF_FFFF)) begin
            run_cnt_d = run_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            off_cnt_q <= OFF_LOAD;
            run_cnt_q <= 32'd0;
            speed     <= 8'd0;
            enable    <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            off_cnt_q <= off_cnt_d;
            run_cnt_q <= run_cnt_d;
            speed     <= speed_d;
            enable    <= enable_d;
            busy      <= busy_d;
            fault     <= fault_d;
            timeout   <= timeout_d;
        end
    end

    assign state = state_q;

endmodule
